// File: rtl/mode_controller.sv
// Watch mode controller: debounces three pushbuttons, steps CLOCK/STOPWATCH/TIMER,
// routes display digits, handles lap freeze and latched timer-expiry alarm.
module mode_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk4,
  input  logic        reset_n,
  input  logic        btn_mode,
  input  logic        btn_action,
  input  logic        btn_lap,
  input  logic [15:0] clk_digits,
  input  logic [15:0] sw_digits,
  input  logic [15:0] tmr_digits,
  input  logic        tmr_expired,
  output logic [1:0]  mode,
  output logic        sw_enable,
  output logic        tmr_enable,
  output logic        sw_start_pause,
  output logic        tmr_start_pause,
  output logic [15:0] disp_digits,
  output logic        lap_active,
  output logic        alarm_led
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    CLOCK     = 2'b00,
    STOPWATCH = 2'b01,
    TIMER     = 2'b10
  } mode_t;

  mode_t          state, state_nxt;
  logic [2:0]     raw, sync1, sync2, level, press;
  logic [CW-1:0]  cnt [3];
  logic [15:0]    lap_reg;
  logic           exp_q;
  logic           mode_p, action_p, lap_p, action_ok;

  assign raw      = {btn_lap, btn_action, btn_mode};
  assign mode_p   = press[0];
  assign action_p = press[1];
  assign lap_p    = press[2];
  // A coincident mode press wins; an action press while the alarm is lit only acknowledges it.
  assign action_ok = action_p & ~mode_p & ~alarm_led;

  always_ff @(posedge clk4 or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != level[i]) begin
          if (cnt[i] == CNT_LAST) begin
            level[i] <= sync2[i];
            cnt[i]   <= '0;
            press[i] <= sync2[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk4 or negedge reset_n) begin
    if (!reset_n) state <= CLOCK;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sw_enable  = 1'b0;
    tmr_enable = 1'b0;
    case (state)
      CLOCK:     if (mode_p) state_nxt = STOPWATCH;
      STOPWATCH: begin
        sw_enable = 1'b1;
        if (mode_p) state_nxt = TIMER;
      end
      TIMER: begin
        tmr_enable = 1'b1;
        if (mode_p) state_nxt = CLOCK;
      end
      default:   state_nxt = CLOCK;
    endcase
  end

  assign mode = state;

  always_ff @(posedge clk4 or negedge reset_n) begin
    if (!reset_n) begin
      sw_start_pause  <= 1'b0;
      tmr_start_pause <= 1'b0;
      lap_active      <= 1'b0;
      lap_reg         <= '0;
      alarm_led       <= 1'b0;
      exp_q           <= 1'b0;
      disp_digits     <= '0;
    end else begin
      sw_start_pause  <= action_ok && (state == STOPWATCH);
      tmr_start_pause <= action_ok && (state == TIMER);

      if (mode_p) begin
        lap_active <= 1'b0;
      end else if (lap_p && (state == STOPWATCH)) begin
        if (!lap_active) lap_reg <= sw_digits;
        lap_active <= ~lap_active;
      end

      exp_q <= tmr_expired;
      if (tmr_expired && !exp_q)   alarm_led <= 1'b1;
      else if (action_p && alarm_led) alarm_led <= 1'b0;

      case (state)
        CLOCK:     disp_digits <= clk_digits;
        STOPWATCH: disp_digits <= lap_active ? lap_reg : sw_digits;
        TIMER:     disp_digits <= tmr_digits;
        default:   disp_digits <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mode_controller.sv
// Scoreboard bench for mode_controller: expected mode steps and start/pause pulses
// are queued as stimulus is applied and matched when the outputs change.
module tb_mode_controller;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = DEB + 6;

  logic        clk4 = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_mode = 1'b0, btn_action = 1'b0, btn_lap = 1'b0;
  logic [15:0] clk_digits = '0, sw_digits = '0, tmr_digits = '0;
  logic        tmr_expired = 1'b0;
  logic [1:0]  mode;
  logic        sw_enable, tmr_enable, sw_start_pause, tmr_start_pause;
  logic [15:0] disp_digits;
  logic        lap_active, alarm_led;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_mode_q [$];
  logic [1:0] exp_pulse_q [$];

  mode_controller #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk4(clk4), .reset_n(reset_n),
    .btn_mode(btn_mode), .btn_action(btn_action), .btn_lap(btn_lap),
    .clk_digits(clk_digits), .sw_digits(sw_digits), .tmr_digits(tmr_digits),
    .tmr_expired(tmr_expired),
    .mode(mode), .sw_enable(sw_enable), .tmr_enable(tmr_enable),
    .sw_start_pause(sw_start_pause), .tmr_start_pause(tmr_start_pause),
    .disp_digits(disp_digits), .lap_active(lap_active), .alarm_led(alarm_led)
  );

  always #20 clk4 = ~clk4;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [1:0] prev_mode  = 2'b00;
  logic [1:0] prev_pulse = 2'b00;

  always @(negedge clk4) begin
    logic [1:0] pulse;
    pulse = {tmr_start_pause, sw_start_pause};
    if (mode !== prev_mode) begin
      if (exp_mode_q.size() == 0) check_eq("mode_unexpected", {30'd0, mode}, {30'd0, prev_mode});
      else                        check_eq("mode_step", {30'd0, mode}, {30'd0, exp_mode_q.pop_front()});
      check_eq("sw_enable", {31'd0, sw_enable}, {31'd0, mode == 2'b01});
      check_eq("tmr_enable", {31'd0, tmr_enable}, {31'd0, mode == 2'b10});
    end
    if (pulse != 2'b00) begin
      if (exp_pulse_q.size() == 0) check_eq("pulse_unexpected", {30'd0, pulse}, 32'd0);
      else                         check_eq("pulse", {30'd0, pulse}, {30'd0, exp_pulse_q.pop_front()});
      check_eq("pulse_width", {30'd0, prev_pulse}, 32'd0);
    end
    prev_mode  = mode;
    prev_pulse = pulse;
  end

  task automatic wait_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk4);
  endtask

  // mask bit0 = mode, bit1 = action, bit2 = lap
  task automatic press(input logic [2:0] mask);
    @(negedge clk4);
    btn_mode   = mask[0];
    btn_action = mask[1];
    btn_lap    = mask[2];
    wait_cycles(HOLD);
    btn_mode   = 1'b0;
    btn_action = 1'b0;
    btn_lap    = 1'b0;
    wait_cycles(HOLD);
  endtask

  task automatic mode_press(input logic [1:0] next);
    exp_mode_q.push_back(next);
    press(3'b001);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mode"}, {30'd0, mode}, 32'd0);
    check_eq({tag, "_sw_en"}, {31'd0, sw_enable}, 32'd0);
    check_eq({tag, "_tmr_en"}, {31'd0, tmr_enable}, 32'd0);
    check_eq({tag, "_sp"}, {30'd0, tmr_start_pause, sw_start_pause}, 32'd0);
    check_eq({tag, "_disp"}, {16'd0, disp_digits}, 32'd0);
    check_eq({tag, "_lap"}, {31'd0, lap_active}, 32'd0);
    check_eq({tag, "_alarm"}, {31'd0, alarm_led}, 32'd0);
  endtask

  initial begin
    #5;
    check_reset_outputs("reset");
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(2);

    // Bouncing mode button: 2-cycle plateaus never satisfy the debounce, then one clean hold.
    exp_mode_q.push_back(2'b01);
    for (int i = 0; i < 10; i++) begin
      btn_mode = ~btn_mode;
      wait_cycles(2);
    end
    btn_mode = 1'b1;
    wait_cycles(HOLD + 4);
    btn_mode = 1'b0;
    wait_cycles(HOLD);
    check_eq("bounce_mode", {30'd0, mode}, 32'd1);

    exp_pulse_q.push_back(2'b01);
    press(3'b010);

    sw_digits = 16'h0123;
    wait_cycles(2);
    check_eq("disp_sw", {16'd0, disp_digits}, 32'h0123);
    press(3'b100);
    check_eq("lap_set", {31'd0, lap_active}, 32'd1);
    sw_digits = 16'h0456;
    wait_cycles(3);
    check_eq("disp_frozen", {16'd0, disp_digits}, 32'h0123);
    press(3'b100);
    check_eq("lap_clear", {31'd0, lap_active}, 32'd0);
    check_eq("disp_live", {16'd0, disp_digits}, 32'h0456);

    mode_press(2'b10);
    mode_press(2'b00);
    press(3'b010);

    clk_digits = 16'h1234;
    #1 check_eq("disp_not_comb", {16'd0, disp_digits}, 32'd0);
    @(negedge clk4);
    check_eq("disp_clock", {16'd0, disp_digits}, 32'h1234);

    tmr_expired = 1'b1;
    wait_cycles(2);
    check_eq("alarm_set", {31'd0, alarm_led}, 32'd1);
    wait_cycles(5);
    check_eq("alarm_hold", {31'd0, alarm_led}, 32'd1);
    press(3'b010);
    check_eq("alarm_ack", {31'd0, alarm_led}, 32'd0);
    tmr_expired = 1'b0;

    mode_press(2'b01);
    mode_press(2'b10);
    tmr_digits = 16'h0930;
    wait_cycles(2);
    check_eq("disp_timer", {16'd0, disp_digits}, 32'h0930);
    exp_pulse_q.push_back(2'b10);
    press(3'b010);

    mode_press(2'b00);
    mode_press(2'b01);
    exp_mode_q.push_back(2'b10);
    press(3'b011);
    check_eq("mode_plus_action", {30'd0, mode}, 32'd2);

    press(3'b100);
    check_eq("lap_ignored_timer", {31'd0, lap_active}, 32'd0);
    mode_press(2'b00);
    mode_press(2'b01);
    press(3'b100);
    check_eq("lap_before_reset", {31'd0, lap_active}, 32'd1);

    exp_mode_q.push_back(2'b00);
    @(negedge clk4);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(4);

    check_eq("mode_q_drained", exp_mode_q.size(), 32'd0);
    check_eq("pulse_q_drained", exp_pulse_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
